// File: rtl/spi_burst_sequencer_if.sv
// Bundle between the OLED controller, the burst sequencer and the SPI MOSI serializer.
// master drives the burst request and serializer pulse; slave is the sequencer.
interface spi_burst_sequencer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 16,
  parameter int unsigned CNT_W = 5
) ();
  logic [WIDTH*N-1:0] req_data;
  logic [N-1:0]       req_dc;
  logic [CNT_W-1:0]   req_n_transmit;
  logic               req_start;
  logic               abort;
  logic               mosi_final_bit;

  logic [WIDTH-1:0]   ser_data;
  logic               ser_dc;
  logic               ser_start;
  logic               mosi_final_byte;
  logic               ready;
  logic               done;
  logic               err;
  logic [CNT_W-1:0]   byte_idx;

  modport master (
    output req_data, req_dc, req_n_transmit, req_start, abort, mosi_final_bit,
    input  ser_data, ser_dc, ser_start, mosi_final_byte, ready, done, err, byte_idx
  );

  modport slave (
    input  req_data, req_dc, req_n_transmit, req_start, abort, mosi_final_bit,
    output ser_data, ser_dc, ser_start, mosi_final_byte, ready, done, err, byte_idx
  );
endinterface

// File: rtl/spi_burst_sequencer.sv
// Latches a burst of up to N bytes with per-byte D/C and feeds one byte per serializer
// final-bit pulse. Define SPI_BURST_CHAIN_EN for gapless chaining of back-to-back bursts.
module spi_burst_sequencer #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned N              = 16,
  parameter int unsigned CNT_W          = 5,
  parameter int unsigned MSB_BYTE_FIRST = 0
) (
  input  logic                 sck,
  input  logic                 rst,
  spi_burst_sequencer_if.slave bus
);
  typedef enum logic [0:0] {StIdle, StXmit} state_e;

  state_e             state_q, state_d;
  logic [WIDTH*N-1:0] data_q, data_d;
  logic [N-1:0]       dc_q, dc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               legal, last, ready, req_ok;
  logic [CNT_W-1:0]   sel;
  logic [WIDTH-1:0]   byte_out;
  logic               dc_out;

`ifdef SPI_BURST_CHAIN_EN
  logic               pend_q, pend_d;
  logic [WIDTH*N-1:0] pend_data_q, pend_data_d;
  logic [N-1:0]       pend_dc_q, pend_dc_d;
  logic [CNT_W-1:0]   pend_cnt_q, pend_cnt_d;
`endif

  assign legal = (bus.req_n_transmit != '0) && (bus.req_n_transmit <= CNT_W'(N));
  assign last  = (idx_q == cnt_q - CNT_W'(1));

`ifdef SPI_BURST_CHAIN_EN
  // Accept the next burst only while the last byte is out and nothing is queued yet.
  assign ready = (state_q == StIdle) || ((state_q == StXmit) && last && !pend_q);
`else
  assign ready = (state_q == StIdle);
`endif

  assign req_ok = ready && bus.req_start && !bus.abort;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dc_d    = dc_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef SPI_BURST_CHAIN_EN
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    pend_dc_d   = pend_dc_q;
    pend_cnt_d  = pend_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_ok) begin
          if (legal) begin
            state_d = StXmit;
            data_d  = bus.req_data;
            dc_d    = bus.req_dc;
            cnt_d   = bus.req_n_transmit;
            idx_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StXmit: begin
        if (bus.abort) begin
          state_d = StIdle;
`ifdef SPI_BURST_CHAIN_EN
          pend_d  = 1'b0;
`endif
        end else begin
`ifdef SPI_BURST_CHAIN_EN
          if (req_ok && !legal) err_d = 1'b1;
          if (req_ok && legal) begin
            pend_d      = 1'b1;
            pend_data_d = bus.req_data;
            pend_dc_d   = bus.req_dc;
            pend_cnt_d  = bus.req_n_transmit;
          end
`endif
          if (bus.mosi_final_bit) begin
            if (!last) begin
              idx_d = idx_q + CNT_W'(1);
            end else begin
              done_d = 1'b1;
`ifdef SPI_BURST_CHAIN_EN
              // A queued burst (possibly captured this very cycle) starts with no gap.
              if (pend_d) begin
                data_d = pend_data_d;
                dc_d   = pend_dc_d;
                cnt_d  = pend_cnt_d;
                idx_d  = '0;
                pend_d = 1'b0;
              end else begin
                state_d = StIdle;
              end
`else
              state_d = StIdle;
`endif
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge sck) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      dc_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef SPI_BURST_CHAIN_EN
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      pend_dc_q   <= '0;
      pend_cnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dc_q    <= dc_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef SPI_BURST_CHAIN_EN
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      pend_dc_q   <= pend_dc_d;
      pend_cnt_q  <= pend_cnt_d;
`endif
    end
  end

  // Presentation index maps to a storage slot; MSB-first walks down from the top slot.
  assign sel = (MSB_BYTE_FIRST != 0) ? (CNT_W'(N - 1) - idx_q) : idx_q;

  always_comb begin
    byte_out = '0;
    dc_out   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sel == CNT_W'(k)) begin
        byte_out = data_q[k*WIDTH +: WIDTH];
        dc_out   = dc_q[k];
      end
    end
  end

  assign bus.ser_data        = byte_out;
  assign bus.ser_dc          = dc_out;
  assign bus.ser_start       = (state_q == StXmit);
  assign bus.mosi_final_byte = (state_q == StXmit) && last;
  assign bus.ready           = ready;
  assign bus.done            = done_q;
  assign bus.err             = err_q;
  assign bus.byte_idx        = idx_q;
endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Bench for spi_burst_sequencer: LSB-first and MSB-first instances (N=4) driven in lockstep,
// checked every cycle against a burst-level model plus hand-computed literal expectations.
module tb_spi_burst_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        s_rst, s_start, s_abort, s_fb;
  logic [31:0] s_data;
  logic [3:0]  s_dc;
  logic [2:0]  s_n;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt0 = 0;
  bit chk_en   = 1'b0;

`ifdef SPI_BURST_CHAIN_EN
  localparam bit Chain = 1'b1;
`else
  localparam bit Chain = 1'b0;
`endif

  spi_burst_sequencer_if #(.WIDTH(8), .N(4), .CNT_W(3)) bus0 ();
  spi_burst_sequencer_if #(.WIDTH(8), .N(4), .CNT_W(3)) bus1 ();

  assign bus0.req_data = s_data;
  assign bus0.req_dc = s_dc;
  assign bus0.req_n_transmit = s_n;
  assign bus0.req_start = s_start;
  assign bus0.abort = s_abort;
  assign bus0.mosi_final_bit = s_fb;
  assign bus1.req_data = s_data;
  assign bus1.req_dc = s_dc;
  assign bus1.req_n_transmit = s_n;
  assign bus1.req_start = s_start;
  assign bus1.abort = s_abort;
  assign bus1.mosi_final_bit = s_fb;

  spi_burst_sequencer #(.WIDTH(8), .N(4), .CNT_W(3), .MSB_BYTE_FIRST(0)) dut0 (
    .sck (clk),
    .rst (s_rst),
    .bus (bus0.slave)
  );

  spi_burst_sequencer #(.WIDTH(8), .N(4), .CNT_W(3), .MSB_BYTE_FIRST(1)) dut1 (
    .sck (clk),
    .rst (s_rst),
    .bus (bus1.slave)
  );

  // Model: each burst is stored in send order; position walks through it.
  logic [7:0]  m_bytes [2][4];
  logic        m_dcs   [2][4];
  int          m_cnt [2];
  int          m_pos [2];
  bit          m_active [2];
  bit          m_done [2];
  bit          m_err [2];
  bit          p_valid [2];
  logic [31:0] p_data [2];
  logic [3:0]  p_dc [2];
  int          p_n [2];

  task automatic m_load(input int d, input logic [31:0] data, input logic [3:0] dc, input int n);
    logic [31:0] tmp;
    int src;
    for (int k = 0; k < 4; k++) begin
      src = (d == 1) ? 3 - k : k;
      tmp = data >> (8 * src);
      m_bytes[d][k] = tmp[7:0];
      m_dcs[d][k] = dc[src];
    end
    m_cnt[d] = n;
    m_pos[d] = 0;
    m_active[d] = 1'b1;
  endtask

  function automatic bit m_ready(input int d);
    return !m_active[d] || (Chain && (m_pos[d] == m_cnt[d] - 1) && !p_valid[d]);
  endfunction

  task automatic m_step(input int d);
    bit legal, take;
    legal = (int'(s_n) >= 1) && (int'(s_n) <= 4);
    take = m_ready(d) && s_start && !s_abort;
    m_done[d] = 1'b0;
    m_err[d] = 1'b0;
    if (s_rst) begin
      for (int k = 0; k < 4; k++) begin
        m_bytes[d][k] = 8'h00;
        m_dcs[d][k] = 1'b0;
      end
      m_cnt[d] = 0;
      m_pos[d] = 0;
      m_active[d] = 1'b0;
      p_valid[d] = 1'b0;
    end else if (!m_active[d]) begin
      if (take) begin
        if (legal) m_load(d, s_data, s_dc, int'(s_n));
        else m_err[d] = 1'b1;
      end
    end else if (s_abort) begin
      m_active[d] = 1'b0;
      p_valid[d] = 1'b0;
    end else begin
      if (take && !legal) m_err[d] = 1'b1;
      if (take && legal) begin
        p_valid[d] = 1'b1;
        p_data[d] = s_data;
        p_dc[d] = s_dc;
        p_n[d] = int'(s_n);
      end
      if (s_fb) begin
        if (m_pos[d] < m_cnt[d] - 1) begin
          m_pos[d]++;
        end else begin
          m_done[d] = 1'b1;
          if (p_valid[d]) begin
            m_load(d, p_data[d], p_dc[d], p_n[d]);
            p_valid[d] = 1'b0;
          end else begin
            m_active[d] = 1'b0;
          end
        end
      end
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) m_step(d);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp(input int d, input logic [7:0] data, input logic dc, input logic start,
                     input logic fbyte, input logic ready, input logic done, input logic err,
                     input logic [2:0] idx);
    check($sformatf("dut%0d data", d), 32'(data), 32'(m_bytes[d][m_pos[d]]));
    check($sformatf("dut%0d dc", d), 32'(dc), 32'(m_dcs[d][m_pos[d]]));
    check($sformatf("dut%0d start", d), 32'(start), 32'(m_active[d]));
    check($sformatf("dut%0d final_byte", d), 32'(fbyte),
          32'(m_active[d] && (m_pos[d] == m_cnt[d] - 1)));
    check($sformatf("dut%0d ready", d), 32'(ready), 32'(m_ready(d)));
    check($sformatf("dut%0d done", d), 32'(done), 32'(m_done[d]));
    check($sformatf("dut%0d err", d), 32'(err), 32'(m_err[d]));
    check($sformatf("dut%0d byte_idx", d), 32'(idx), m_pos[d]);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, bus0.ser_data, bus0.ser_dc, bus0.ser_start, bus0.mosi_final_byte, bus0.ready,
          bus0.done, bus0.err, bus0.byte_idx);
      cmp(1, bus1.ser_data, bus1.ser_dc, bus1.ser_start, bus1.mosi_final_byte, bus1.ready,
          bus1.done, bus1.err, bus1.byte_idx);
      if (bus0.done === 1'b1) done_cnt0++;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic go(input logic [2:0] n, input logic [31:0] data, input logic [3:0] dc);
    s_n = n;
    s_data = data;
    s_dc = dc;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
  endtask

  task automatic pulses(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      repeat (gap - 1) step();
      s_fb = 1'b1;
      step();
      s_fb = 1'b0;
    end
  endtask

  initial begin
    s_rst = 1'b1;
    s_start = 1'b0;
    s_abort = 1'b0;
    s_fb = 1'b0;
    s_data = '0;
    s_dc = '0;
    s_n = '0;
    step();
    chk_en = 1'b1;
    step();
    s_rst = 1'b0;
    step();
    check("reset ready", 32'(bus0.ready), 32'd1);
    check("reset start", 32'(bus0.ser_start), 32'd0);
    check("reset data", 32'(bus0.ser_data), 32'h00);

    // Four-byte burst, both byte orders; late data change must not leak in.
    go(3'd4, 32'hDDCCBBAA, 4'b0101);
    check("lsb first byte", 32'(bus0.ser_data), 32'hAA);
    check("lsb first dc", 32'(bus0.ser_dc), 32'd1);
    check("msb first byte", 32'(bus1.ser_data), 32'hDD);
    check("msb first dc", 32'(bus1.ser_dc), 32'd0);
    check("model lsb order", {m_bytes[0][0], m_bytes[0][1], m_bytes[0][2], m_bytes[0][3]},
          32'hAABBCCDD);
    check("model msb order", {m_bytes[1][0], m_bytes[1][1], m_bytes[1][2], m_bytes[1][3]},
          32'hDDCCBBAA);
    check("model lsb dc order", 32'({m_dcs[0][0], m_dcs[0][1], m_dcs[0][2], m_dcs[0][3]}),
          32'b1010);
    check("model msb dc order", 32'({m_dcs[1][0], m_dcs[1][1], m_dcs[1][2], m_dcs[1][3]}),
          32'b0101);
    s_data = 32'h12345678;
    pulses(3, 8);
    check("lsb last byte", 32'(bus0.ser_data), 32'hDD);
    check("lsb final_byte", 32'(bus0.mosi_final_byte), 32'd1);
    check("msb last byte", 32'(bus1.ser_data), 32'hAA);
    pulses(1, 8);
    check("done pulse", 32'(bus0.done), 32'd1);
    check("start low after done", 32'(bus0.ser_start), 32'd0);
    step();
    check("done one cycle", 32'(bus0.done), 32'd0);

    // Reset in the middle of a burst.
    go(3'd4, 32'h44332211, 4'b1111);
    pulses(2, 4);
    check("mid burst idx", 32'(bus0.byte_idx), 32'd2);
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    check("rst start", 32'(bus0.ser_start), 32'd0);
    check("rst ready", 32'(bus0.ready), 32'd1);
    check("rst data", 32'(bus0.ser_data), 32'h00);
    check("rst done", 32'(bus0.done), 32'd0);

    // Single-byte burst and illegal counts.
    step();
    go(3'd1, 32'h0000005A, 4'b0001);
    check("single byte data", 32'(bus0.ser_data), 32'h5A);
    check("single final_byte", 32'(bus0.mosi_final_byte), 32'd1);
    pulses(1, 3);
    check("single done", 32'(bus0.done), 32'd1);
    go(3'd0, 32'hFFFFFFFF, 4'hF);
    check("count0 err", 32'(bus0.err), 32'd1);
    check("count0 start", 32'(bus0.ser_start), 32'd0);
    step();
    check("err one cycle", 32'(bus0.err), 32'd0);
    go(3'd5, 32'hFFFFFFFF, 4'hF);
    check("count5 err", 32'(bus1.err), 32'd1);
    check("count5 start", 32'(bus1.ser_start), 32'd0);

    // Abort coincident with the second final-bit pulse of a three-byte burst.
    step();
    go(3'd3, 32'h00332211, 4'b0010);
    pulses(1, 2);
    go(3'd2, 32'h0000CAFE, 4'b0000);
    check("start ignored idx", 32'(bus0.byte_idx), 32'd1);
    check("start ignored data", 32'(bus0.ser_data), 32'h22);
    s_fb = 1'b1;
    s_abort = 1'b1;
    step();
    s_fb = 1'b0;
    s_abort = 1'b0;
    check("abort idx held", 32'(bus0.byte_idx), 32'd1);
    check("abort start", 32'(bus0.ser_start), 32'd0);
    check("abort no done", 32'(bus0.done), 32'd0);
    go(3'd2, 32'h0000BEEF, 4'b0011);
    check("restart after abort", 32'(bus0.ser_start), 32'd1);
    check("restart data", 32'(bus0.ser_data), 32'hEF);
    pulses(2, 2);
    step();

    // Abort in idle blocks a coincident start.
    s_abort = 1'b1;
    go(3'd2, 32'h00000102, 4'b0000);
    s_abort = 1'b0;
    check("idle abort blocks start", 32'(bus0.ser_start), 32'd0);

`ifdef SPI_BURST_CHAIN_EN
    step();
    done_cnt0 = 0;
    go(3'd2, 32'h0000BBAA, 4'b0000);
    pulses(1, 4);
    check("chain window ready", 32'(bus0.ready), 32'd1);
    go(3'd2, 32'h00001122, 4'b0000);
    check("chain pending ready", 32'(bus0.ready), 32'd0);
    pulses(1, 4);
    check("chain start held", 32'(bus0.ser_start), 32'd1);
    check("chain next byte", 32'(bus0.ser_data), 32'h22);
    pulses(1, 4);
    check("chain second byte", 32'(bus0.ser_data), 32'h11);
    pulses(1, 4);
    step();
    check("chain done count", done_cnt0, 32'd2);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
